// File: rtl/link_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_framer
// Description : Pops words from an upstream FIFO and frames them onto a
//               registered valid/ready link with sop/eop packet markers.
// Revision    : 1.0 - initial release
// ============================================================================
module link_tx_framer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic              link_valid,
    input  logic              link_ready,
    output logic [DATA_W-1:0] link_data,
    output logic              link_sop,
    output logic              link_eop,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);

    localparam logic [0:0]       c_st_head = 1'b0;
    localparam logic [0:0]       c_st_body = 1'b1;
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [0:0]        r_state;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_link_valid;
    logic [DATA_W-1:0] r_link_data;
    logic              r_link_sop;
    logic              r_link_eop;
    logic [CNT_W-1:0]  r_pkt_count;

    logic              w_load;
    logic              w_accept;
    logic [LEN_W-1:0]  w_len;

    // The reset term keeps the FIFO untouched while the block is held in reset.
    assign w_load       = ~reset & ~fifo_empty & (~r_link_valid | link_ready);
    assign w_accept     = r_link_valid & link_ready;
    assign w_len        = fifo_data[LEN_W-1:0];
    assign fifo_read_en = w_load;

    assign link_valid = r_link_valid;
    assign link_data  = r_link_data;
    assign link_sop   = r_link_sop;
    assign link_eop   = r_link_eop;
    assign pkt_count  = r_pkt_count;
    assign busy       = (r_state == c_st_body) | r_link_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_head;
            r_remaining  <= '0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
            r_link_sop   <= 1'b0;
            r_link_eop   <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            if (w_load) begin
                r_link_valid <= 1'b1;
                r_link_data  <= fifo_data;
                if (r_state == c_st_head) begin
                    r_link_sop <= 1'b1;
                    if (w_len == '0) begin
                        r_link_eop <= 1'b1;
                    end else begin
                        r_link_eop  <= 1'b0;
                        r_remaining <= w_len;
                        r_state     <= c_st_body;
                    end
                end else begin
                    r_link_sop  <= 1'b0;
                    r_link_eop  <= (r_remaining == c_len_one);
                    r_remaining <= r_remaining - c_len_one;
                    if (r_remaining == c_len_one) begin
                        r_state <= c_st_head;
                    end
                end
            end else if (w_accept) begin
                r_link_valid <= 1'b0;
            end

            if (w_accept && r_link_eop) begin
                r_pkt_count <= r_pkt_count + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_link_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_tx_framer
// Description : Directed and randomized bench for link_tx_framer against a
//               queue-based packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_tx_framer;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } word_t;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_read_en;
    logic        link_valid;
    logic        link_ready;
    logic [31:0] link_data;
    logic        link_sop;
    logic        link_eop;
    logic [15:0] pkt_count;
    logic        busy;

    word_t       fifo_q[$];  // words offered by the upstream FIFO
    word_t       exp_q[$];   // words popped but not yet accepted on the link
    logic [15:0] exp_cnt;
    bit          mid_pkt;
    int          n_assert;
    int          n_fail;

    link_tx_framer #(.DATA_W(32), .LEN_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .link_valid   (link_valid),
        .link_ready   (link_ready),
        .link_data    (link_data),
        .link_sop     (link_sop),
        .link_eop     (link_eop),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] data, input bit sop, input bit eop);
        word_t w;
        w.data = data;
        w.sop  = sop;
        w.eop  = eop;
        fifo_q.push_back(w);
    endtask

    // A packet is a header carrying its payload count in the low byte,
    // followed by that many payload words; only the last word has eop.
    task automatic push_pkt(input int len);
        logic [31:0] hdr;
        hdr = {$urandom()} & 32'hFFFF_FF00;
        hdr[7:0] = 8'(len);
        push_word(hdr, 1'b1, len == 0);
        for (int i = 1; i <= len; i++) push_word($urandom(), 1'b0, i == len);
    endtask

    task automatic model_clear();
        fifo_q.delete();
        exp_q.delete();
        exp_cnt = '0;
        mid_pkt = 1'b0;
    endtask

    task automatic cycle(input bit rdy, input bit gate);
        bit exp_valid, exp_load, do_acc;
        word_t w;
        @(negedge clk);
        link_ready = rdy;
        if (fifo_q.size() != 0 && !gate) begin
            fifo_empty = 1'b0;
            fifo_data  = fifo_q[0].data;
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = $urandom();
        end
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_load  = !fifo_empty && (!exp_valid || rdy);
        chk("link_valid", link_valid, exp_valid);
        if (exp_valid) begin
            chk("link_data", link_data, exp_q[0].data);
            chk("link_sop", link_sop, exp_q[0].sop);
            chk("link_eop", link_eop, exp_q[0].eop);
        end
        chk("fifo_read_en", fifo_read_en, exp_load);
        chk("pkt_count", pkt_count, exp_cnt);
        chk("busy", busy, mid_pkt || exp_valid);
        do_acc = exp_valid && rdy;
        @(posedge clk);
        if (do_acc) begin
            if (exp_q[0].eop) exp_cnt = exp_cnt + 16'd1;
            void'(exp_q.pop_front());
        end
        if (exp_load) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            mid_pkt = !w.eop;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk("drain_timeout", 64'(fifo_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, link_valid, 1'b0);
        chk({tag, "_data"}, link_data, 32'd0);
        chk({tag, "_sop"}, link_sop, 1'b0);
        chk({tag, "_eop"}, link_eop, 1'b0);
        chk({tag, "_cnt"}, pkt_count, 16'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rd"}, fifo_read_en, 1'b0);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        model_clear();
        reset      = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 32'h0000_0005;
        link_ready = 1'b1;

        // Reset: outputs cleared and no pop even with data available.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all_zero("reset");
        fifo_empty = 1'b1;
        reset = 1'b0;

        // Header len=3 plus three payloads streamed back to back.
        push_word(32'h0000_0003, 1'b1, 1'b0);
        push_word(32'h1111_1111, 1'b0, 1'b0);
        push_word(32'h2222_2222, 1'b0, 1'b0);
        push_word(32'h3333_3333, 1'b0, 1'b1);
        drain(20);
        @(negedge clk);
        #1;
        chk("basic_pkt_count", pkt_count, 16'd1);

        // Zero-length packet.
        push_word(32'hABCD_0000, 1'b1, 1'b1);
        drain(10);

        // Backpressure for 5 cycles mid-packet.
        push_pkt(6);
        repeat (3) cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        drain(30);

        // FIFO underflow mid-packet, refilled 10 cycles later.
        push_word(32'h1234_0002, 1'b1, 1'b0);
        push_word(32'hAAAA_0001, 1'b0, 1'b0);
        repeat (12) cycle(1'b1, 1'b0);
        push_word(32'hBBBB_0002, 1'b0, 1'b1);
        drain(10);

        // Maximum length field.
        push_pkt(255);
        drain(400);

        // Randomized packets with random FIFO gaps and link backpressure.
        for (int p = 0; p < 40; p++) push_pkt($urandom_range(0, 12));
        for (int c = 0; c < 4000 && (fifo_q.size() != 0 || exp_q.size() != 0); c++)
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
        drain(2000);

        // Reset while in BODY with five payloads still owed.
        push_word(32'h5A5A_0008, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) push_word({$urandom()} | 32'd1, 1'b0, 1'b0);
        repeat (4) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        @(negedge clk);
        fifo_empty = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        push_pkt(1);
        drain(10);

        // Counter wrap after 65536 delivered packets.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int p = 0; p < 65536; p++) push_pkt(0);
        drain(70000);
        @(negedge clk);
        #1;
        chk("wrap_pkt_count", pkt_count, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
